// File: rtl/within_window_checker.sv
// Hardware monitor for the "inner within outer" relation; emits pass/fail pulses.
// Optional pass/fail statistic counters are built when WITHIN_CHECKER_STATS_EN is defined.
module within_window_checker #(
   parameter int MAX_WINDOW = 32,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             start_i,
   input  logic             end_i,
   input  logic             inner_i,
   output logic             window_o,
   output logic             pass_o,
   output logic             fail_o,
   output logic [1:0]       fail_code_o,
   output logic [CNT_W-1:0] pass_cnt_o,
   output logic [CNT_W-1:0] fail_cnt_o
);

   localparam int WC_W = $clog2(MAX_WINDOW + 1);
   localparam logic [WC_W-1:0] MAX_CNT = WC_W'(MAX_WINDOW);

   localparam logic [1:0] C_NONE     = 2'd0;
   localparam logic [1:0] C_ORPHAN   = 2'd1;
   localparam logic [1:0] C_NO_INNER = 2'd2;
   localparam logic [1:0] C_TIMEOUT  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_OUTER,
      S_INNER,
      S_SEEN
   } state_t;

   state_t          state_q, state_d;
   logic [WC_W-1:0] wcnt_q, wcnt_d;
   logic            window_q, window_d;
   logic            pass_q, pass_d;
   logic            fail_q, fail_d;
   logic [1:0]      code_q, code_d;

   logic [WC_W-1:0] wcnt_inc;
   logic            hit_max;

   // Length of the window including the current sample.
   assign wcnt_inc = (state_q == S_IDLE) ? WC_W'(1)
                                         : wcnt_q + WC_W'(1);
   assign hit_max  = (wcnt_inc == MAX_CNT);

   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      window_d = window_q;
      pass_d   = 1'b0;
      fail_d   = 1'b0;
      code_d   = C_NONE;
      if (en_i) begin
         // Stays high through the cycle that reports the close.
         window_d = (state_q != S_IDLE) | start_i;
         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  if (end_i) begin
                     if (inner_i) begin
                        pass_d = 1'b1;
                     end else begin
                        fail_d = 1'b1;
                        code_d = C_NO_INNER;
                     end
                  end else if (hit_max) begin
                     fail_d = 1'b1;
                     code_d = C_TIMEOUT;
                  end else if (inner_i) begin
                     state_d = S_INNER;
                  end else begin
                     state_d = S_OUTER;
                  end
               end else if (inner_i) begin
                  fail_d = 1'b1;
                  code_d = C_ORPHAN;
               end
            end
            S_OUTER: begin
               if (end_i) begin
                  state_d = S_IDLE;
                  if (inner_i) begin
                     pass_d = 1'b1;
                  end else begin
                     fail_d = 1'b1;
                     code_d = C_NO_INNER;
                  end
               end else if (hit_max) begin
                  state_d = S_IDLE;
                  fail_d  = 1'b1;
                  code_d  = C_TIMEOUT;
               end else if (inner_i) begin
                  state_d = S_INNER;
               end
            end
            S_INNER: begin
               if (end_i) begin
                  state_d = S_IDLE;
                  pass_d  = 1'b1;
               end else if (hit_max) begin
                  state_d = S_IDLE;
                  fail_d  = 1'b1;
                  code_d  = C_TIMEOUT;
               end else if (!inner_i) begin
                  state_d = S_SEEN;
               end
            end
            S_SEEN: begin
               if (end_i) begin
                  state_d = S_IDLE;
                  pass_d  = 1'b1;
               end else if (hit_max) begin
                  state_d = S_IDLE;
                  fail_d  = 1'b1;
                  code_d  = C_TIMEOUT;
               end else if (inner_i) begin
                  state_d = S_INNER;
               end
            end
         endcase
         wcnt_d = (state_d == S_IDLE) ? '0 : wcnt_inc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         wcnt_q   <= '0;
         window_q <= 1'b0;
         pass_q   <= 1'b0;
         fail_q   <= 1'b0;
         code_q   <= C_NONE;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         window_q <= window_d;
         pass_q   <= pass_d;
         fail_q   <= fail_d;
         code_q   <= code_d;
      end
   end

   assign window_o    = window_q;
   assign pass_o      = pass_q;
   assign fail_o      = fail_q;
   assign fail_code_o = fail_q ? code_q : C_NONE;

`ifdef WITHIN_CHECKER_STATS_EN
   logic [CNT_W-1:0] pcnt_q, pcnt_d;
   logic [CNT_W-1:0] fcnt_q, fcnt_d;

   // Saturating; counts move in step with the pulse they record.
   always_comb begin
      pcnt_d = pcnt_q;
      fcnt_d = fcnt_q;
      if (pass_d && (pcnt_q != '1)) begin
         pcnt_d = pcnt_q + CNT_W'(1);
      end
      if (fail_d && (fcnt_q != '1)) begin
         fcnt_d = fcnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_q <= '0;
         fcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
         fcnt_q <= fcnt_d;
      end
   end

   assign pass_cnt_o = pcnt_q;
   assign fail_cnt_o = fcnt_q;
`else
   assign pass_cnt_o = '0;
   assign fail_cnt_o = '0;
`endif

endmodule

// File: tb/tb_within_window_checker.sv
// Directed bench for within_window_checker: vector table plus long-window sequences.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_within_window_checker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en_i = 1'b0;
   logic        start_i = 1'b0;
   logic        end_i = 1'b0;
   logic        inner_i = 1'b0;

   logic        window_o, pass_o, fail_o;
   logic [1:0]  fail_code_o;
   logic [15:0] pass_cnt_o, fail_cnt_o;

   logic        window2, pass2, fail2;
   logic [1:0]  code2;
   logic [1:0]  pcnt2, fcnt2;

   int checks = 0;
   int errors = 0;
   int npass  = 0;
   int nfail  = 0;

   always #5 clk = ~clk;

   within_window_checker #(.MAX_WINDOW(32), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .en_i(en_i),
      .start_i(start_i), .end_i(end_i), .inner_i(inner_i),
      .window_o(window_o), .pass_o(pass_o), .fail_o(fail_o),
      .fail_code_o(fail_code_o),
      .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o)
   );

   within_window_checker #(.MAX_WINDOW(32), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .en_i(en_i),
      .start_i(start_i), .end_i(end_i), .inner_i(inner_i),
      .window_o(window2), .pass_o(pass2), .fail_o(fail2),
      .fail_code_o(code2),
      .pass_cnt_o(pcnt2), .fail_cnt_o(fcnt2)
   );

   typedef struct {
      logic       s, e, i, n;
      logic       p, f;
      logic [1:0] c;
      logic       w;
   } vec_t;

   vec_t vecs[16];

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   function automatic int sat(int v, int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic step(input logic s, e, i, n, p, f,
                       input logic [1:0] c, input logic w,
                       input string tag);
      start_i = s;
      end_i   = e;
      inner_i = i;
      en_i    = n;
      @(posedge clk);
      #1;
      chk({tag, ".pass"},   pass_o,      p);
      chk({tag, ".fail"},   fail_o,      f);
      chk({tag, ".code"},   fail_code_o, c);
      chk({tag, ".window"}, window_o,    w);
      chk({tag, ".pass2"},  pass2,       p);
      chk({tag, ".fail2"},  fail2,       f);
      if (p) npass++;
      if (f) nfail++;
   endtask

   task automatic quiet(input int k, input string tag);
      for (int j = 0; j < k; j++) begin
         step(0, 0, 0, 1, 0, 0, 2'd0, 0, tag);
      end
   endtask

   task automatic chk_cnt(input string tag);
`ifdef WITHIN_CHECKER_STATS_EN
      chk({tag, ".pcnt"},  pass_cnt_o, sat(npass, 65535));
      chk({tag, ".fcnt"},  fail_cnt_o, sat(nfail, 65535));
      chk({tag, ".pcnt2"}, pcnt2,      sat(npass, 3));
      chk({tag, ".fcnt2"}, fcnt2,      sat(nfail, 3));
`else
      chk({tag, ".pcnt"},  pass_cnt_o, 0);
      chk({tag, ".fcnt"},  fail_cnt_o, 0);
      chk({tag, ".pcnt2"}, pcnt2,      0);
      chk({tag, ".fcnt2"}, fcnt2,      0);
`endif
   endtask

   initial begin
      vecs[0]  = '{1, 1, 1, 1, 1, 0, 2'd0, 1};
      vecs[1]  = '{1, 1, 0, 1, 0, 1, 2'd2, 1};
      vecs[2]  = '{0, 0, 0, 1, 0, 0, 2'd0, 0};
      vecs[3]  = '{0, 0, 1, 1, 0, 1, 2'd1, 0};
      vecs[4]  = '{0, 0, 1, 0, 0, 0, 2'd0, 0};
      vecs[5]  = '{1, 0, 1, 1, 0, 0, 2'd0, 1};
      vecs[6]  = '{0, 1, 0, 0, 0, 0, 2'd0, 1};
      vecs[7]  = '{0, 1, 0, 0, 0, 0, 2'd0, 1};
      vecs[8]  = '{0, 0, 0, 1, 0, 0, 2'd0, 1};
      vecs[9]  = '{1, 0, 0, 1, 0, 0, 2'd0, 1};
      vecs[10] = '{0, 1, 0, 1, 1, 0, 2'd0, 1};
      vecs[11] = '{1, 0, 0, 1, 0, 0, 2'd0, 1};
      vecs[12] = '{0, 1, 1, 1, 1, 0, 2'd0, 1};
      vecs[13] = '{0, 0, 0, 1, 0, 0, 2'd0, 0};
      vecs[14] = '{1, 0, 0, 0, 0, 0, 2'd0, 0};
      vecs[15] = '{0, 0, 0, 1, 0, 0, 2'd0, 0};

      #23;
      chk("rst.window", window_o, 0);
      chk("rst.pass",   pass_o,   0);
      chk("rst.fail",   fail_o,   0);
      chk("rst.code",   fail_code_o, 0);
      chk_cnt("rst");
      @(negedge clk);
      rst_n = 1'b1;
      quiet(2, "idle");

      for (int k = 0; k < 16; k++) begin
         step(vecs[k].s, vecs[k].e, vecs[k].i, vecs[k].n,
              vecs[k].p, vecs[k].f, vecs[k].c, vecs[k].w,
              $sformatf("vec%0d", k));
      end

      // Window of 11 samples, inner inside it.
      step(1, 0, 0, 1, 0, 0, 2'd0, 1, "s1");
      for (int k = 1; k < 10; k++) begin
         step(0, 0, (k >= 2 && k <= 8), 1, 0, 0, 2'd0, 1, "s1");
      end
      step(0, 1, 0, 1, 1, 0, 2'd0, 1, "s1.end");
      quiet(1, "s1.after");

      // Window with no inner.
      step(1, 0, 0, 1, 0, 0, 2'd0, 1, "s2");
      quiet_open(9, "s2");
      step(0, 1, 0, 1, 0, 1, 2'd2, 1, "s2.end");
      quiet(1, "s2.after");

      // Inner outlives the window by one cycle.
      step(1, 0, 0, 1, 0, 0, 2'd0, 1, "s3");
      for (int k = 1; k < 10; k++) begin
         step(0, 0, (k >= 2), 1, 0, 0, 2'd0, 1, "s3");
      end
      step(0, 1, 1, 1, 1, 0, 2'd0, 1, "s3.end");
      step(0, 0, 1, 1, 0, 1, 2'd1, 0, "s3.orphan");
      quiet(1, "s3.after");

      // No end: timeout on the 32nd sample.
      step(1, 0, 0, 1, 0, 0, 2'd0, 1, "s4");
      quiet_open(30, "s4");
      step(0, 0, 0, 1, 0, 1, 2'd3, 1, "s4.tmo");
      quiet(1, "s4.after");

      // End exactly on the 32nd sample closes normally.
      step(1, 0, 1, 1, 0, 0, 2'd0, 1, "s5");
      for (int k = 1; k < 31; k++) begin
         step(0, 0, 1, 1, 0, 0, 2'd0, 1, "s5");
      end
      step(0, 1, 1, 1, 1, 0, 2'd0, 1, "s5.end");
      step(0, 0, 0, 1, 0, 0, 2'd0, 0, "s5.after");

      // Two inner intervals, a second start ignored.
      step(1, 0, 1, 1, 0, 0, 2'd0, 1, "s6.3");
      step(0, 0, 1, 1, 0, 0, 2'd0, 1, "s6.4");
      step(1, 0, 0, 1, 0, 0, 2'd0, 1, "s6.5");
      step(0, 0, 1, 1, 0, 0, 2'd0, 1, "s6.6");
      step(0, 0, 0, 1, 0, 0, 2'd0, 1, "s6.7");
      step(0, 1, 0, 1, 1, 0, 2'd0, 1, "s6.8");
      quiet(1, "s6.after");
      chk_cnt("mid");

      // Asynchronous reset mid-window.
      step(1, 0, 0, 1, 0, 0, 2'd0, 1, "s7");
      step(0, 0, 1, 1, 0, 0, 2'd0, 1, "s7");
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.window", window_o, 0);
      chk("arst.pass",   pass_o,   0);
      chk("arst.fail",   fail_o,   0);
      npass = 0;
      nfail = 0;
      chk_cnt("arst");
      @(negedge clk);
      rst_n = 1'b1;
      inner_i = 1'b0;
      quiet(2, "s7.after");

      for (int k = 0; k < 3; k++) begin
         step(1, 1, 1, 1, 1, 0, 2'd0, 1, "s8");
      end
      quiet(1, "s8");
      chk_cnt("three");
      for (int k = 0; k < 2; k++) begin
         step(1, 1, 1, 1, 1, 0, 2'd0, 1, "s9");
      end
      quiet(1, "s9");
      chk_cnt("five");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   task automatic quiet_open(input int k, input string tag);
      for (int j = 0; j < k; j++) begin
         step(0, 0, 0, 1, 0, 0, 2'd0, 1, tag);
      end
   endtask

endmodule
